// File: rtl/foc_loop_scheduler.sv
// foc_loop_scheduler
// Period sequencer for the FOC current loop. Each control period it requests
// an electrical-angle sample, latches the returned angle, fires the current
// loop with that angle held stable and waits for modulation-done.
// Period overruns (ticks while a sequence is in flight) are flagged and
// counted.
// Optional feature, enabled by defining FOC_SCHED_TIMEOUT_EN: a wait-state
// watchdog that sets a sticky fault and aborts a stalled sequence.
// oDbg_state exposes the FSM state for debug and checker binding.
//
// Handshake semantics (all single-cycle pulses, no back-pressure):
//   oEnc_req       : one-cycle request, issued in ENC_REQ only.
//   iEnc_done      : accepted only while in ENC_WAIT; iTheta is sampled in the
//                    same cycle. Pulses in any other state are ignored.
//   oCL_en         : one-cycle start, issued in CL_START with oTheta_elec
//                    already updated and held until the next accepted angle.
//   iModulate_done : accepted only while in MOD_WAIT; ignored elsewhere.
module foc_loop_scheduler #(
  parameter int PERIOD  = 5000,
  parameter int TIMEOUT = 2000,
  parameter int THETA_W = 20
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iRun,
  input  logic               iClr,
  input  logic               iEnc_done,
  input  logic [THETA_W-1:0] iTheta,
  input  logic               iModulate_done,
  output logic               oEnc_req,
  output logic               oCL_en,
  output logic [THETA_W-1:0] oTheta_elec,
  output logic               oBusy,
  output logic               oOverrun,
  output logic [7:0]         oOverrun_cnt,
  output logic               oFault,
  output logic [2:0]         oDbg_state
);

  localparam int CNT_W = $clog2(PERIOD);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENC_REQ  = 3'd1,
    S_ENC_WAIT = 3'd2,
    S_CL_START = 3'd3,
    S_MOD_WAIT = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] period_cnt;
  logic             tick;
  logic             theta_load;
  logic             drop;
  logic             timeout_hit;
  logic             fault_q;

  // Tick is decoded from the registered period counter, so it is glitch-free
  // and aligned with the last cycle of each period.
  assign tick = iRun && (period_cnt == CNT_W'(PERIOD - 1));

  // A tick that finds a sequence still in flight is dropped and counted.
  assign drop = tick && (state != S_IDLE) && !fault_q;

  // Period counter: counts 0..PERIOD-1 while running, held at 0 when stopped.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      period_cnt <= '0;
    end else if (!iRun || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

`ifdef FOC_SCHED_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              fault_set;

  // The wait states are only entered from ENC_REQ / CL_START, so clearing in
  // those states gives a count of 0 on the first cycle of each wait.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wait_cnt <= '0;
    end else if (state == S_ENC_REQ || state == S_CL_START) begin
      wait_cnt <= '0;
    end else if (state == S_ENC_WAIT || state == S_MOD_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == S_ENC_WAIT || state == S_MOD_WAIT) &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // Fault fires only when the last allowed wait cycle brings no acknowledge.
  assign fault_set = timeout_hit &&
                     ((state == S_ENC_WAIT && !iEnc_done) ||
                      (state == S_MOD_WAIT && !iModulate_done));

  // Sticky fault; a same-cycle set beats iClr.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end else if (iClr) begin
      fault_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fault_q     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and angle-load decode.
  always_comb begin
    state_nxt  = state;
    theta_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick && !fault_q) state_nxt = S_ENC_REQ;
      end
      S_ENC_REQ: begin
        state_nxt = S_ENC_WAIT;
      end
      S_ENC_WAIT: begin
        if (iEnc_done) begin
          theta_load = 1'b1;
          state_nxt  = S_CL_START;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_CL_START: begin
        state_nxt = S_MOD_WAIT;
      end
      S_MOD_WAIT: begin
        if (iModulate_done || timeout_hit) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Angle latch: only an accepted encoder response updates it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oTheta_elec <= '0;
    end else if (theta_load) begin
      oTheta_elec <= iTheta;
    end
  end

  // Overrun flag and saturating count; a same-cycle drop beats iClr.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oOverrun     <= 1'b0;
      oOverrun_cnt <= 8'd0;
    end else if (drop) begin
      oOverrun <= 1'b1;
      if (iClr) begin
        oOverrun_cnt <= 8'd1;
      end else if (oOverrun_cnt != 8'hFF) begin
        oOverrun_cnt <= oOverrun_cnt + 8'd1;
      end
    end else if (iClr) begin
      oOverrun     <= 1'b0;
      oOverrun_cnt <= 8'd0;
    end
  end

  assign oEnc_req   = (state == S_ENC_REQ);
  assign oCL_en     = (state == S_CL_START);
  assign oBusy      = (state != S_IDLE);
  assign oFault     = fault_q;
  assign oDbg_state = state;

endmodule
